// File: rtl/prog_loader_if.sv
// Byte-stream, CPU memory-port and RAM-port signals of the program loader.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready qualifies in_valid; the RAM side has no backpressure.
//
// Signals:
//   in_valid/in_data/in_ready     boot byte stream, big-endian words
//   cpu_wrEn/cpu_addr/cpu_data    SimpleCPU memory request
//   ram_wrEn/ram_addr/ram_data    blram write/address port
//   cpu_rst, done, err            CPU reset and loader status
//   words_loaded                  number of words written so far
// Modports: slave = the loader, master = whatever drives the stream and CPU.
interface prog_loader_if #(
  parameter int SIZE = 10
);
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            cpu_wrEn;
  logic [SIZE-1:0] cpu_addr;
  logic [31:0]     cpu_data;
  logic            ram_wrEn;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_data;
  logic            cpu_rst;
  logic            done;
  logic            err;
  logic [15:0]     words_loaded;

  modport slave (
    input  in_valid, in_data, cpu_wrEn, cpu_addr, cpu_data,
    output in_ready, ram_wrEn, ram_addr, ram_data, cpu_rst, done, err, words_loaded
  );

  modport master (
    output in_valid, in_data, cpu_wrEn, cpu_addr, cpu_data,
    input  in_ready, ram_wrEn, ram_addr, ram_data, cpu_rst, done, err, words_loaded
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: assembles a header plus N big-endian words from a byte stream into blram, then hands RAM to the CPU.
// Latency: RAM write one cycle after a word's last byte; RUN-mode pass-through is combinational (zero cycles).
// Backpressure: in_ready drops for the single write cycle and permanently once in RUN or ERR.
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   bus        prog_loader_if.slave (stream in, CPU port in, RAM port and status out)
module prog_loader #(
  parameter int          SIZE  = 10,
  parameter int          DEPTH = 1024,
  parameter logic [15:0] MAGIC = 16'hC0DE
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    WR,
    RUN,
    ERR
  } state_t;

  // One extra bit so a DEPTH of 65536 still compares correctly against a 16-bit count.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q;
  logic [31:0] shift_q;
  logic [15:0] n_q;
  logic [15:0] words_q;   // doubles as the write address: word i always goes to address i

  logic        in_rdy;
  logic        xfer;
  logic        last_byte;
  logic [31:0] word_next;
  logic        latch_n;
  logic        wr_fire;

  assign in_rdy    = (state_q == HDR) || (state_q == LOAD);
  assign xfer      = bus.in_valid && in_rdy;
  assign last_byte = xfer && (byte_cnt_q == 2'd3);
  assign word_next = {shift_q[23:0], bus.in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HDR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    latch_n      = 1'b0;
    wr_fire      = 1'b0;
    bus.ram_wrEn = 1'b0;
    bus.ram_addr = '0;
    bus.ram_data = '0;
    bus.cpu_rst  = 1'b1;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    unique case (state_q)
      HDR: begin
        if (last_byte) begin
          if (word_next[31:16] != MAGIC)                state_d = ERR;
          else if ({1'b0, word_next[15:0]} > DEPTH_L)   state_d = ERR;
          else if (word_next[15:0] == 16'd0)            state_d = RUN;
          else begin
            latch_n = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (last_byte) state_d = WR;
      end
      WR: begin
        // shift_q cannot change here because in_ready is low, so it is the finished word.
        wr_fire      = 1'b1;
        bus.ram_wrEn = 1'b1;
        bus.ram_addr = words_q[SIZE-1:0];
        bus.ram_data = shift_q;
        if (words_q + 16'd1 == n_q) state_d = RUN;
        else                        state_d = LOAD;
      end
      RUN: begin
        bus.cpu_rst  = 1'b0;
        bus.done     = 1'b1;
        bus.ram_wrEn = bus.cpu_wrEn;
        bus.ram_addr = bus.cpu_addr;
        bus.ram_data = bus.cpu_data;
      end
      ERR: begin
        bus.err = 1'b1;
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'd0;
      n_q        <= 16'd0;
      words_q    <= 16'd0;
    end else begin
      if (xfer) begin
        shift_q    <= word_next;
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (latch_n) n_q <= word_next[15:0];
      // WR always leaves for RUN once the count reaches N, so words_q saturates at N.
      if (wr_fire) words_q <= words_q + 16'd1;
    end
  end

  assign bus.in_ready     = in_rdy;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and randomized byte streams
// checked against a header/word model, plus RUN-mode pass-through checks.
// Stream driver honours in_ready; the CPU port is driven directly.
module tb_prog_loader;
  localparam int          SIZE  = 10;
  localparam int          DEPTH = 1024;
  localparam logic [15:0] MAGIC = 16'hC0DE;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct {
    int              cyc;
    logic [SIZE-1:0] addr;
    logic [31:0]     data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if #(.SIZE(SIZE)) bus();

  prog_loader #(.SIZE(SIZE), .DEPTH(DEPTH), .MAGIC(MAGIC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_low = 0;
  int xfer_q[$];
  wr_t wr_q[$];
  wr_t mw;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) xfer_q.push_back(cyc);
      if (!bus.done && !bus.err && !bus.in_ready) rdy_low++;
      if (bus.ram_wrEn && !bus.done) begin
        mw.cyc  = cyc;
        mw.addr = bus.ram_addr;
        mw.data = bus.ram_data;
        wr_q.push_back(mw);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t mk_stream(input logic [31:0] hdr, input wq_t words);
    bq_t q;
    for (int k = 3; k >= 0; k--) q.push_back(hdr[k*8 +: 8]);
    foreach (words[i]) for (int k = 3; k >= 0; k--) q.push_back(words[i][k*8 +: 8]);
    return q;
  endfunction

  task automatic clear_mon();
    xfer_q.delete();
    wr_q.delete();
    rdy_low = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.cpu_wrEn = 1'b1;
    bus.cpu_addr = '1;
    bus.cpu_data = '1;
    @(posedge clk); #1;
    chk("rst_ram_wrEn", bus.ram_wrEn === 1'b0, bus.ram_wrEn, 1'b0);
    chk("rst_ram_addr", bus.ram_addr === 10'd0, bus.ram_addr, 10'd0);
    chk("rst_ram_data", bus.ram_data === 32'd0, bus.ram_data, 32'd0);
    chk("rst_cpu_rst", bus.cpu_rst === 1'b1, bus.cpu_rst, 1'b1);
    chk("rst_done", bus.done === 1'b0, bus.done, 1'b0);
    chk("rst_err", bus.err === 1'b0, bus.err, 1'b0);
    chk("rst_in_ready", bus.in_ready === 1'b1, bus.in_ready, 1'b1);
    chk("rst_words", bus.words_loaded === 16'd0, bus.words_loaded, 16'd0);
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      bus.cpu_wrEn = 1'($urandom);
      bus.cpu_addr = SIZE'($urandom);
      bus.cpu_data = $urandom;
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("byte_accept", ok === 1'b1, ok, 1'b1);
  endtask

  task automatic run_stream(input bq_t bytes, input int gap_lo, input int gap_hi, input bit with_rst);
    logic [31:0] hdr;
    logic [15:0] n;
    bit          exp_err;
    int          consumed;
    logic [31:0] w;
    if (with_rst) do_reset();
    hdr      = {bytes[0], bytes[1], bytes[2], bytes[3]};
    exp_err  = (hdr[31:16] != MAGIC) || (int'(hdr[15:0]) > DEPTH);
    n        = exp_err ? 16'd0 : hdr[15:0];
    consumed = exp_err ? 4 : 4 + 4 * int'(n);
    for (int i = 0; i < consumed; i++) begin
      send_byte(bytes[i], $urandom_range(gap_hi, gap_lo));
      if (i == 3) begin
        if (exp_err) begin
          chk("hdr_err_now", bus.err === 1'b1, bus.err, 1'b1);
          chk("hdr_err_ready", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
          chk("hdr_err_cpu_rst", bus.cpu_rst === 1'b1, bus.cpu_rst, 1'b1);
        end else if (n == 16'd0) begin
          chk("hdr_zero_done_now", bus.done === 1'b1, bus.done, 1'b1);
        end
      end
    end
    @(negedge clk);
    for (int c = 0; c < 10 && !(bus.done || bus.err); c++) @(negedge clk);
    chk("end_done", bus.done === !exp_err, bus.done, !exp_err);
    chk("end_err", bus.err === exp_err, bus.err, exp_err);
    chk("end_cpu_rst", bus.cpu_rst === exp_err, bus.cpu_rst, exp_err);
    chk("end_in_ready", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
    chk("end_words", bus.words_loaded === n, bus.words_loaded, n);
    chk("write_count", wr_q.size() === int'(n), wr_q.size(), int'(n));
    chk("byte_count", xfer_q.size() === consumed, xfer_q.size(), consumed);
    chk("ready_low_cycles", rdy_low === int'(n), rdy_low, int'(n));
    for (int i = 0; i < int'(n) && i < wr_q.size(); i++) begin
      w = {bytes[4+4*i], bytes[5+4*i], bytes[6+4*i], bytes[7+4*i]};
      chk("wr_addr", wr_q[i].addr === SIZE'(i), wr_q[i].addr, SIZE'(i));
      chk("wr_data", wr_q[i].data === w, wr_q[i].data, w);
      if (xfer_q.size() > 7 + 4 * i)
        chk("wr_timing", wr_q[i].cyc === xfer_q[7+4*i] + 1, wr_q[i].cyc, xfer_q[7+4*i] + 1);
    end
  endtask

  initial begin
    bq_t         s;
    wq_t         ws;
    logic [15:0] m;
    logic [15:0] wl;
    int          nx;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.cpu_wrEn = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;

    ws = '{32'h20114045, 32'h10114001};
    s  = mk_stream(32'hC0DE0002, ws);
    run_stream(s, 0, 0, 1'b1);
    if (wr_q.size() == 2) begin
      chk("t1_data0", wr_q[0].data === 32'h20114045, wr_q[0].data, 32'h20114045);
      chk("t1_data1", wr_q[1].data === 32'h10114001, wr_q[1].data, 32'h10114001);
    end
    chk("t1_words", bus.words_loaded === 16'd2, bus.words_loaded, 16'd2);

    bus.cpu_wrEn = 1'b1; bus.cpu_addr = 10'h045; bus.cpu_data = 32'd7;
    #1;
    chk("run_wrEn", bus.ram_wrEn === 1'b1, bus.ram_wrEn, 1'b1);
    chk("run_addr", bus.ram_addr === 10'h045, bus.ram_addr, 10'h045);
    chk("run_data", bus.ram_data === 32'd7, bus.ram_data, 32'd7);
    for (int i = 0; i < 4; i++) begin
      bus.cpu_wrEn = 1'($urandom);
      bus.cpu_addr = SIZE'($urandom);
      bus.cpu_data = $urandom;
      #1;
      chk("run_rand_wrEn", bus.ram_wrEn === bus.cpu_wrEn, bus.ram_wrEn, bus.cpu_wrEn);
      chk("run_rand_addr", bus.ram_addr === bus.cpu_addr, bus.ram_addr, bus.cpu_addr);
      chk("run_rand_data", bus.ram_data === bus.cpu_data, bus.ram_data, bus.cpu_data);
    end
    nx = xfer_q.size();
    bus.in_valid = 1'b1; bus.in_data = 8'hC0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("run_in_ready", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
    chk("run_words_hold", bus.words_loaded === 16'd2, bus.words_loaded, 16'd2);
    chk("run_no_consume", xfer_q.size() === nx, xfer_q.size(), nx);
    bus.in_valid = 1'b0;

    run_stream(mk_stream(32'hDEAD0001, '{}), 0, 0, 1'b1);
    run_stream(mk_stream(32'hC0DE0000, '{}), 0, 0, 1'b1);
    run_stream(mk_stream(32'hC0DE0401, '{}), 0, 0, 1'b1);

    run_stream(mk_stream(32'hC0DE0002, '{32'h20114045, 32'h10114001}), 3, 3, 1'b1);

    do_reset();
    s = mk_stream(32'hC0DE0003, '{32'hA5A55A5A, 32'h01020304});
    for (int i = 0; i < 10; i++) send_byte(s[i], 0);
    chk("mid_words_before", bus.words_loaded === 16'd1, bus.words_loaded, 16'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_words", bus.words_loaded === 16'd0, bus.words_loaded, 16'd0);
    chk("mid_rst_cpu_rst", bus.cpu_rst === 1'b1, bus.cpu_rst, 1'b1);
    chk("mid_rst_in_ready", bus.in_ready === 1'b1, bus.in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    run_stream(mk_stream(32'hC0DE0001, '{32'hCAFEF00D}), 0, 1, 1'b0);

    ws = '{};
    for (int i = 0; i < DEPTH; i++) ws.push_back($urandom);
    run_stream(mk_stream({MAGIC, 16'(DEPTH)}, ws), 0, 0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      ws = '{};
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) ws.push_back($urandom);
      run_stream(mk_stream({MAGIC, 16'(ws.size())}, ws), 0, 2, 1'b1);
    end

    for (int t = 0; t < 3; t++) begin
      m = 16'($urandom);
      if (m == MAGIC) m = m ^ 16'h0001;
      run_stream(mk_stream({m, 16'($urandom)}, '{}), 0, 2, 1'b1);
      wl = 16'($urandom_range(65535, DEPTH + 1));
      run_stream(mk_stream({MAGIC, wl}, '{}), 0, 2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
